switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/scic_io_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 52 +++++
 rtl/switch_debouncer.sv | 81 ++++++++
 tb/tb_switch_debouncer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/scic_io_pkg.sv
// Shared constants and types for the SCIC board I/O blocks.
//   DEF_WIDTH           - default number of switch bits
//   DEF_DEBOUNCE_CYCLES - default qualification length in clock cycles
//   cnt_w()             - width of a counter that must reach n-1 without wrapping
//   ev_op_e             - per-edge action on the change-event register
package scic_io_pkg;

  localparam int unsigned DEF_WIDTH           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

  // ceil(log2(n)), floored at 1 bit so the smallest legal length still has a counter.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    EV_IDLE = 2'd0,  // nothing to do
    EV_ACK  = 2'd1,  // consumer drained the pending event
    EV_NEW  = 2'd2,  // update with no event left un-consumed
    EV_OVR  = 2'd3   // update on top of an un-acked event
  } ev_op_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, saturating qualification
// counter and the debounced output flop.
//   clock, reset - rising-edge clock, async active-low reset
//   raw          - asynchronous switch level
//   db           - debounced level
//   upd          - high in the cycle whose rising edge will change db
//   nxt          - value db will take on the next edge
module debounce_bit
  import scic_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic upd,
  output logic nxt
);

  localparam int unsigned     CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          diff;

  assign diff = sync[1] ^ db;
  // Accept on the edge where the mismatch has already been seen
  // DEBOUNCE_CYCLES-1 times; counter never exceeds CNT_MAX.
  assign upd  = diff && (cnt == CNT_MAX);
  assign nxt  = upd ? sync[1] : db;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (!diff) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        db  <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH board switches and raises a change event per update.
//   clock, reset  - rising-edge clock, async active-low reset
//   switches_raw  - asynchronous switch levels
//   switches      - debounced, synchronous switch value
//   changed       - one-cycle pulse after any debounced update
//   event_valid   - change event pending, cleared by event_ack
//   event_data    - debounced value at the most recent change
//   event_ack     - consumer acknowledge
//   overrun       - sticky: an update landed on an un-acked event
module switch_debouncer
  import scic_io_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic             changed,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_data,
  input  logic             event_ack,
  output logic             overrun
);

  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] nxt;
  logic             any_upd;
  ev_op_e           ev_op;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock (clock),
      .reset (reset),
      .raw   (switches_raw[g]),
      .db    (switches[g]),
      .upd   (upd[g]),
      .nxt   (nxt[g])
    );
  end

  assign any_upd = |upd;

  // An update always wins over an ack; an ack coinciding with an update
  // counts as consuming the old event, so it is not an overrun.
  always_comb begin
    ev_op = EV_IDLE;
    if (any_upd)
      ev_op = (event_valid && !event_ack) ? EV_OVR : EV_NEW;
    else if (event_valid && event_ack)
      ev_op = EV_ACK;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      changed     <= 1'b0;
      event_valid <= 1'b0;
      event_data  <= '0;
      overrun     <= 1'b0;
    end else begin
      changed <= any_upd;
      case (ev_op)
        EV_NEW: begin
          event_valid <= 1'b1;
          event_data  <= nxt;
        end
        EV_OVR: begin
          event_valid <= 1'b1;
          event_data  <= nxt;
          overrun     <= 1'b1;
        end
        EV_ACK:  event_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] switches_raw = '0;
  logic [W-1:0] switches;
  logic         changed;
  logic         event_valid;
  logic [W-1:0] event_data;
  logic         event_ack = 1'b0;
  logic         overrun;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .switches_raw (switches_raw),
    .switches     (switches),
    .changed      (changed),
    .event_valid  (event_valid),
    .event_data   (event_data),
    .event_ack    (event_ack),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (changed === 1'b1) pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    // reset state and idle hold
    tick(2);
    chk("rst_sw", switches, 0);
    chk("rst_ev", event_valid, 0);
    reset = 1'b1;
    p0 = pulses;
    tick(20);
    chk("idle_sw", switches, 0);
    chk("idle_pulse", pulses - p0, 0);
    chk("idle_ev", event_valid, 0);
    chk("idle_ovr", overrun, 0);

    // 0000 -> 0101, latency N+2 edges
    p0 = pulses;
    switches_raw = 4'b0101;
    tick(N + 1);
    chk("lat_early", switches, 0);
    chk("lat_early_chg", changed, 0);
    tick(1);
    chk("lat_sw", switches, 4'b0101);
    chk("lat_chg", changed, 1);
    chk("lat_ev", event_valid, 1);
    chk("lat_data", event_data, 4'b0101);
    tick(1);
    chk("lat_chg_drop", changed, 0);
    chk("lat_pulses", pulses - p0, 1);
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    chk("ack_ev", event_valid, 0);
    chk("ack_data", event_data, 4'b0101);
    // ack with nothing pending
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    chk("idle_ack_ev", event_valid, 0);
    chk("idle_ack_ovr", overrun, 0);

    // glitch of N-1 cycles must be filtered
    switches_raw = 4'b0000;
    do_reset();
    p0 = pulses;
    switches_raw = 4'b0001;
    tick(N - 1);
    switches_raw = 4'b0000;
    tick(10);
    chk("glitch_sw", switches, 0);
    chk("glitch_pulse", pulses - p0, 0);
    chk("glitch_ev", event_valid, 0);

    // overrun: two updates without ack
    switches_raw = 4'b0001;
    tick(N + 2);
    chk("ovr_sw1", switches, 4'b0001);
    chk("ovr_ev1", event_valid, 1);
    chk("ovr_flag1", overrun, 0);
    switches_raw = 4'b0011;
    tick(N + 2);
    chk("ovr_sw2", switches, 4'b0011);
    chk("ovr_data", event_data, 4'b0011);
    chk("ovr_ev2", event_valid, 1);
    chk("ovr_flag2", overrun, 1);
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    chk("ovr_ack_ev", event_valid, 0);
    tick(3);
    chk("ovr_sticky", overrun, 1);
    reset = 1'b0;
    #1;
    chk("async_ovr", overrun, 0);
    chk("async_sw", switches, 0);
    chk("async_data", event_data, 0);
    tick(2);
    switches_raw = 4'b0000;
    reset = 1'b1;

    // ack on the same edge as an update
    do_reset();
    switches_raw = 4'b0001;
    tick(N + 2);
    chk("coin_pre_ev", event_valid, 1);
    switches_raw = 4'b1000;
    tick(N + 1);
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    chk("coin_sw", switches, 4'b1000);
    chk("coin_chg", changed, 1);
    chk("coin_ev", event_valid, 1);
    chk("coin_data", event_data, 4'b1000);
    chk("coin_ovr", overrun, 0);
    tick(1);
    chk("coin_ev_hold", event_valid, 1);

    // reset mid-count abandons qualification
    switches_raw = 4'b0000;
    do_reset();
    switches_raw = 4'b1111;
    tick(3);
    reset = 1'b0;
    #1;
    chk("mid_sw", switches, 0);
    chk("mid_chg", changed, 0);
    chk("mid_ev", event_valid, 0);
    chk("mid_data", event_data, 0);
    chk("mid_ovr", overrun, 0);
    tick(2);
    reset = 1'b1;
    tick(N + 1);
    chk("mid_early", switches, 0);
    tick(1);
    chk("mid_sw_final", switches, 4'b1111);
    chk("mid_ev_final", event_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
